// File: rtl/student_event_latch8.sv
// Sticky 8-bit event/pending register with a 4-phase read handshake.
// Optional build macro EDGE_DETECT_EN: rising-edge event qualification.
module student_event_latch8 #(
   parameter int WIDTH    = 8,
   parameter int OVF_BITS = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [WIDTH-1:0]    ev_in,
   input  logic [WIDTH-1:0]    ev_mask,
   input  logic                rd_req,
   output logic                rd_ack,
   output logic [WIDTH-1:0]    rd_data,
   output logic [OVF_BITS-1:0] rd_ovf,
   output logic [WIDTH-1:0]    pending
);

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_t;

   localparam logic [OVF_BITS-1:0] OVF_MAX = '1;
   localparam logic [OVF_BITS-1:0] OVF_ONE = OVF_BITS'(1);

   state_t              state_q;
   state_t              state_d;
   logic                capture;
   logic                ack_d;
   logic [WIDTH-1:0]    ev_qual;
   logic [WIDTH-1:0]    ev_set;
   logic [WIDTH-1:0]    clr;
   logic [WIDTH-1:0]    pending_d;
   logic [OVF_BITS-1:0] ovf_q;
   logic [OVF_BITS-1:0] ovf_d;
   logic                ovf_hit;

`ifdef EDGE_DETECT_EN
   logic [WIDTH-1:0] ev_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ev_prev <= '0;
      end else begin
         ev_prev <= ev_in;
      end
   end

   assign ev_qual = ev_in & ~ev_prev;
`else
   assign ev_qual = ev_in;
`endif

   assign ev_set = ev_qual & ev_mask;

   // Handshake FSM: capture happens only on the IDLE->ACK transition.
   always_comb begin
      state_d = state_q;
      ack_d   = rd_ack;
      capture = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rd_req) begin
               capture = 1'b1;
               ack_d   = 1'b1;
               state_d = ACK;
            end
         end
         ACK: begin
            if (!rd_req) begin
               ack_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            ack_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rd_ack  <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_ack  <= ack_d;
      end
   end

   // Set wins over clear, so an event in the capture cycle stays pending.
   always_comb begin
      clr       = capture ? pending : '0;
      pending_d = (pending & ~clr) | ev_set;
      ovf_hit   = |(ev_set & pending);
      ovf_d     = ovf_q;
      if (capture) begin
         ovf_d = '0;
      end else if (ovf_hit && (ovf_q != OVF_MAX)) begin
         ovf_d = ovf_q + OVF_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         ovf_q   <= '0;
      end else begin
         pending <= pending_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
         rd_ovf  <= '0;
      end else if (capture) begin
         rd_data <= pending;
         rd_ovf  <= ovf_q;
      end
   end

endmodule

// File: tb/tb_student_event_latch8.sv
// Directed self-checking bench for student_event_latch8.
// Expectations adapt to the EDGE_DETECT_EN build macro.
module tb_student_event_latch8;

   logic       clk;
   logic       rst_n;
   logic [7:0] ev_in;
   logic [7:0] ev_mask;
   logic       rd_req;
   logic       rd_ack;
   logic [7:0] rd_data;
   logic [0:0] rd_ovf;
   logic [7:0] pending;

   int n_cmp;
   int n_err;

   student_event_latch8 #(.WIDTH(8), .OVF_BITS(1)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ev_in   (ev_in),
      .ev_mask (ev_mask),
      .rd_req  (rd_req),
      .rd_ack  (rd_ack),
      .rd_data (rd_data),
      .rd_ovf  (rd_ovf),
      .pending (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      ev_in   = '0;
      ev_mask = 8'hFF;
      rd_req  = 1'b0;
      tick();
      tick();
      n_cmp++;
      if ({rd_ack, rd_ovf, rd_data, pending} !== 18'h0) begin
         n_err++;
         $display("FAIL reset_init: got ack=%b ovf=%b data=%h pend=%h want all 0",
                  rd_ack, rd_ovf, rd_data, pending);
      end
      rst_n = 1'b1;
      tick();
      ev_in = 8'h05;
      tick();
      ev_in = 8'h00;
      tick();
      ev_in = 8'h05;
      tick();
      ev_in = 8'h00;
      tick();
      rd_req = 1'b1;
      tick();
      ev_in = 8'h40;
      tick();
      ev_in = 8'h00;
      n_cmp++;
      if (rd_ack !== 1'b1 || rd_data !== 8'h05 || rd_ovf !== 1'b1 ||
          pending !== 8'h40) begin
         n_err++;
         $display("FAIL reset_preack: got ack=%b data=%h ovf=%b pend=%h want 1 05 1 40",
                  rd_ack, rd_data, rd_ovf, pending);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({rd_ack, rd_ovf, rd_data, pending} !== 18'h0) begin
         n_err++;
         $display("FAIL reset_async: got ack=%b ovf=%b data=%h pend=%h want all 0",
                  rd_ack, rd_ovf, rd_data, pending);
      end
      rd_req = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      rd_req = 1'b1;
      tick();
      n_cmp++;
      if (rd_ack !== 1'b1 || rd_data !== 8'h00) begin
         n_err++;
         $display("FAIL reset_idle: got ack=%b data=%h want 1 00", rd_ack, rd_data);
      end
      rd_req = 1'b0;
      tick();
   endtask

   task automatic test_capture();
      ev_in = 8'h01;
      tick();
      ev_in = 8'h26;
      tick();
      ev_in = 8'h00;
      n_cmp++;
      if (pending !== 8'h27 || (|pending) !== 1'b1) begin
         n_err++;
         $display("FAIL cap_pending: got %h want 27", pending);
      end
      rd_req = 1'b1;
      tick();
      n_cmp++;
      if (rd_ack !== 1'b1 || rd_data !== 8'h27 || pending !== 8'h00 ||
          rd_ovf !== 1'b0) begin
         n_err++;
         $display("FAIL cap_read: got ack=%b data=%h pend=%h ovf=%b want 1 27 00 0",
                  rd_ack, rd_data, pending, rd_ovf);
      end
      rd_req = 1'b0;
      tick();
      n_cmp++;
      if (rd_ack !== 1'b0 || rd_data !== 8'h27) begin
         n_err++;
         $display("FAIL cap_release: got ack=%b data=%h want 0 27", rd_ack, rd_data);
      end
   endtask

   task automatic test_set_on_capture();
      ev_in = 8'h01;
      tick();
      ev_in  = 8'h10;
      rd_req = 1'b1;
      tick();
      ev_in = 8'h00;
      n_cmp++;
      if (rd_data !== 8'h01 || pending !== 8'h10 || rd_ack !== 1'b1) begin
         n_err++;
         $display("FAIL set_on_cap: got data=%h pend=%h ack=%b want 01 10 1",
                  rd_data, pending, rd_ack);
      end
      rd_req = 1'b0;
      tick();
      rd_req = 1'b1;
      tick();
      n_cmp++;
      if (rd_data !== 8'h10 || pending !== 8'h00) begin
         n_err++;
         $display("FAIL set_on_cap_next: got data=%h pend=%h want 10 00",
                  rd_data, pending);
      end
      rd_req = 1'b0;
      tick();
   endtask

   task automatic test_mask();
      ev_mask = 8'hEF;
      ev_in   = 8'h10;
      tick();
      ev_in = 8'h00;
      tick();
      n_cmp++;
      if (pending !== 8'h00 || (|pending) !== 1'b0) begin
         n_err++;
         $display("FAIL mask_block: got pend=%h want 00", pending);
      end
      ev_mask = 8'hFF;
      ev_in   = 8'h20;
      tick();
      ev_in   = 8'h00;
      ev_mask = 8'h00;
      tick();
      n_cmp++;
      if (pending !== 8'h20) begin
         n_err++;
         $display("FAIL mask_keep: got pend=%h want 20", pending);
      end
      ev_mask = 8'hFF;
      rd_req  = 1'b1;
      tick();
      rd_req = 1'b0;
      tick();
   endtask

   task automatic test_overflow();
      ev_in = 8'h01;
      tick();
      ev_in = 8'h00;
      tick();
      ev_in = 8'h01;
      tick();
      ev_in = 8'h00;
      tick();
      rd_req = 1'b1;
      tick();
      n_cmp++;
      if (rd_data !== 8'h01 || rd_ovf !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_first: got data=%h ovf=%b want 01 1", rd_data, rd_ovf);
      end
      rd_req = 1'b0;
      tick();
      ev_in = 8'h04;
      tick();
      ev_in  = 8'h00;
      rd_req = 1'b1;
      tick();
      n_cmp++;
      if (rd_data !== 8'h04 || rd_ovf !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_cleared: got data=%h ovf=%b want 04 0", rd_data, rd_ovf);
      end
      rd_req = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      ev_in = 8'h08;
      tick();
      ev_in  = 8'h00;
      rd_req = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         ev_in = (i == 1) ? 8'h80 : 8'h00;
         tick();
         n_cmp++;
         if (rd_ack !== 1'b1 || rd_data !== 8'h08) begin
            n_err++;
            $display("FAIL held_req[%0d]: got ack=%b data=%h want 1 08",
                     i, rd_ack, rd_data);
         end
      end
      ev_in = 8'h00;
      n_cmp++;
      if (pending !== 8'h80) begin
         n_err++;
         $display("FAIL held_pend: got %h want 80", pending);
      end
      rd_req = 1'b0;
      tick();
      n_cmp++;
      if (rd_ack !== 1'b0) begin
         n_err++;
         $display("FAIL held_drop: got ack=%b want 0", rd_ack);
      end
      rd_req = 1'b1;
      tick();
      n_cmp++;
      if (rd_ack !== 1'b1 || rd_data !== 8'h80 || pending !== 8'h00) begin
         n_err++;
         $display("FAIL rereq: got ack=%b data=%h pend=%h want 1 80 00",
                  rd_ack, rd_data, pending);
      end
      rd_req = 1'b0;
      tick();
   endtask

   task automatic test_held_level();
      logic [0:0] exp_ovf;
      logic [7:0] exp_pend;
`ifdef EDGE_DETECT_EN
      exp_ovf  = 1'b0;
      exp_pend = 8'h00;
`else
      exp_ovf  = 1'b1;
      exp_pend = 8'h01;
`endif
      ev_in = 8'hFF;
      repeat (4) tick();
      ev_in  = 8'h00;
      tick();
      rd_req = 1'b1;
      tick();
      n_cmp++;
      if (rd_data !== 8'hFF || rd_ovf !== exp_ovf) begin
         n_err++;
         $display("FAIL held_ff: got data=%h ovf=%b want ff %b",
                  rd_data, rd_ovf, exp_ovf);
      end
      rd_req = 1'b0;
      tick();
      ev_in = 8'h01;
      tick();
      rd_req = 1'b1;
      tick();
      n_cmp++;
      if (rd_data !== 8'h01 || pending !== exp_pend) begin
         n_err++;
         $display("FAIL held_recap: got data=%h pend=%h want 01 %h",
                  rd_data, pending, exp_pend);
      end
      ev_in  = 8'h00;
      rd_req = 1'b0;
      tick();
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      tick();
      n_cmp++;
      if (pending !== 8'h00) begin
         n_err++;
         $display("FAIL held_clear: got pend=%h want 00", pending);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_capture();
      test_set_on_capture();
      test_mask();
      test_overflow();
      test_back_to_back();
      test_held_level();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
